pll_lock_supervisor: RTL and testbench
======================================

PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

Interface
REQ-001 SHALL have parameter RST_PULSE_CYC, default 24, meaning PLL reset pulse length in refclk cycles (1 us at 24 MHz).
REQ-002 SHALL have parameter LOCK_STABLE_CYC, default 2400, meaning consecutive synchronized-lock cycles required before release.
REQ-003 SHALL have parameter LOCK_TIMEOUT_CYC, default 24000, meaning maximum cycles from PLL reset release to stable lock.
REQ-004 SHALL have parameter MAX_RETRIES, default 3, meaning PLL reset retries before declaring failure (1..3).
REQ-005 SHALL have port refclk, input, 1, the single clock for all logic (free-running PLL reference).
REQ-006 SHALL have port reset, input, 1, reset; synchronous, active-high.
REQ-007 SHALL have port extlock, input, 1, PLL lock indication, asynchronous to refclk.
REQ-008 SHALL have port relock_req, input, 1, single-cycle request to force a full re-lock sequence.
REQ-009 SHALL have port pll_reset, output, 1, drives the PLL reset pin, active-high.
REQ-010 SHALL have port sys_rst, output, 1, active-high downstream reset; consumers resynchronize into clk0_out.
REQ-011 SHALL have ports locked (output, 1, supervisor in RUN), fail (output, 1, supervisor in FAIL) and retry_cnt (output, 2, retries used).

Function
REQ-012 SHALL pass extlock through a 2-flop synchronizer; lock_s is the second flop, so a change on extlock is visible to the FSM after 2 refclk edges.
REQ-013 SHALL implement states RESET_PLL, WAIT_LOCK, STABLE, RUN, FAIL; all outputs registered and decoded from state.
REQ-014 RESET_PLL: pll_reset=1, sys_rst=1; after RST_PULSE_CYC cycles in state -> WAIT_LOCK with the timeout timer cleared.
REQ-015 WAIT_LOCK: pll_reset=0; lock_s=1 -> STABLE with stable counter cleared; timeout timer reaching LOCK_TIMEOUT_CYC -> retry rule (REQ-018).
REQ-016 STABLE: lock_s=0 -> WAIT_LOCK; the timeout timer keeps running across WAIT_LOCK/STABLE and is not cleared by lock glitches; stable counter reaching LOCK_STABLE_CYC -> RUN, retry_cnt cleared.
REQ-017 RUN: sys_rst=0, locked=1; lock_s=0 (loss of lock) or relock_req=1 -> RESET_PLL; sys_rst and pll_reset reassert on the next edge.
REQ-018 Retry rule: retry_cnt<MAX_RETRIES -> retry_cnt+1, RESET_PLL; otherwise -> FAIL.
REQ-019 FAIL: pll_reset=1, sys_rst=1, fail=1, locked=0; left only by relock_req (retry_cnt cleared, -> RESET_PLL) or reset.
REQ-020 relock_req in RESET_PLL restarts the pulse count; in WAIT_LOCK/STABLE -> RESET_PLL without consuming a retry.
REQ-021 Simultaneous timeout and lock_s=1 in WAIT_LOCK: timeout wins.
REQ-022 Counters sized by $clog2 of their limit and never wrap; each counter clears on state entry.

Reset
REQ-023 On reset: state=RESET_PLL, pll_reset=1, sys_rst=1, locked=0, fail=0, retry_cnt=0, counters and synchronizer flops 0.
REQ-024 Reset asserted mid-sequence (any state) SHALL restart from RESET_PLL on the next edge, with no retained retry history.

Configuration
REQ-025 Macro PLL_SUP_LOSS_CNT_EN defined: adds output lock_loss_cnt (8 bits), incremented on each RUN->RESET_PLL transition caused by lock_s=0 (not by relock_req), saturating at 255, cleared only by reset.
REQ-026 Macro undefined: lock_loss_cnt port and logic absent; all other behaviour identical.

Structure
REQ-027 Shared package pll_sup_pkg SHALL hold the state encoding constants and parameter defaults.
REQ-028 Synchronizer SHALL be the sub-module sync_2ff; the FSM and counters reside in pll_lock_supervisor.

Verification (RST_PULSE_CYC=4, LOCK_STABLE_CYC=8, LOCK_TIMEOUT_CYC=32, MAX_RETRIES=2)
REQ-029 Reset release, extlock=1 at cycle 10 -> pll_reset low at cycle 4; locked=1, sys_rst=0 at cycle 10+2+8 (+/-1 per registered output); retry_cnt=0.
REQ-030 extlock held 0 -> two 4-cycle pll_reset pulses, retry_cnt 1 then 2, then fail=1 with pll_reset=1 held; relock_req -> retry_cnt=0, new pulse.
REQ-031 In RUN, extlock drops for 1 cycle -> sys_rst=1 and pll_reset=1 within 3 edges; lock_loss_cnt=1 when the macro is defined.
REQ-032 extlock toggling every 5 cycles in STABLE -> no RUN; timeout at 32 cycles after reset release -> retry_cnt=1.
REQ-033 reset asserted in STABLE with retry_cnt=1 -> next edge all outputs at reset values, retry_cnt=0.

Source files
------------

// File: rtl/pll_sup_pkg.sv
// PLL lock supervisor shared package.
// State encoding and parameter defaults.
package pll_sup_pkg;

    localparam int RST_PULSE_CYC_DEF    = 24;
    localparam int LOCK_STABLE_CYC_DEF  = 2400;
    localparam int LOCK_TIMEOUT_CYC_DEF = 24000;
    localparam int MAX_RETRIES_DEF      = 3;

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAIL      = 3'd4
    } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
// Ports: clk, reset (sync, active-high), d (async in), q (synchronized out).
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses PLL reset, qualifies lock, retries, fails.
// Ports: refclk, reset, extlock, relock_req in; pll_reset, sys_rst, locked,
// fail, retry_cnt out; lock_loss_cnt out when PLL_SUP_LOSS_CNT_EN is defined.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_PULSE_CYC    = RST_PULSE_CYC_DEF,
    parameter int LOCK_STABLE_CYC  = LOCK_STABLE_CYC_DEF,
    parameter int LOCK_TIMEOUT_CYC = LOCK_TIMEOUT_CYC_DEF,
    parameter int MAX_RETRIES      = MAX_RETRIES_DEF
) (
    input  logic       refclk,
    input  logic       reset,
    input  logic       extlock,
    input  logic       relock_req,
    output logic       pll_reset,
    output logic       sys_rst,
    output logic       locked,
    output logic       fail,
`ifdef PLL_SUP_LOSS_CNT_EN
    output logic [7:0] lock_loss_cnt,
`endif
    output logic [1:0] retry_cnt
);

    localparam int PW = $clog2(RST_PULSE_CYC + 1);
    localparam int SW = $clog2(LOCK_STABLE_CYC + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT_CYC + 1);

    localparam logic [PW-1:0] P_LAST = PW'(RST_PULSE_CYC - 1);
    localparam logic [SW-1:0] S_LAST = SW'(LOCK_STABLE_CYC - 1);
    localparam logic [TW-1:0] T_LAST = TW'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [1:0]    R_MAX  = 2'(MAX_RETRIES);

    logic          lock_s;
    state_t        state, state_n;
    logic [PW-1:0] pcnt, pcnt_n;
    logic [SW-1:0] scnt, scnt_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic [1:0]    retry_n;
    logic          tmo_done;

`ifdef PLL_SUP_LOSS_CNT_EN
    logic          loss_inc;
`endif

    sync_2ff u_sync (
        .clk   (refclk),
        .reset (reset),
        .d     (extlock),
        .q     (lock_s)
    );

    assign tmo_done = (tcnt == T_LAST);

    always_comb begin
        state_n = state;
        pcnt_n  = pcnt;
        scnt_n  = scnt;
        tcnt_n  = tcnt;
        retry_n = retry_cnt;
`ifdef PLL_SUP_LOSS_CNT_EN
        loss_inc = 1'b0;
`endif
        unique case (state)
            S_RESET_PLL: begin
                if (relock_req) begin
                    pcnt_n = '0;
                end else if (pcnt == P_LAST) begin
                    state_n = S_WAIT_LOCK;
                    tcnt_n  = '0;
                end else begin
                    pcnt_n = pcnt + 1'b1;
                end
            end
            S_WAIT_LOCK, S_STABLE: begin
                if (relock_req) begin
                    state_n = S_RESET_PLL;
                    pcnt_n  = '0;
                end else if (tmo_done) begin
                    // Timeout wins over a lock seen the same cycle.
                    if (retry_cnt < R_MAX) begin
                        retry_n = retry_cnt + 1'b1;
                        state_n = S_RESET_PLL;
                        pcnt_n  = '0;
                    end else begin
                        state_n = S_FAIL;
                    end
                end else begin
                    // Timer spans lock glitches between the two states.
                    tcnt_n = tcnt + 1'b1;
                    if (state == S_WAIT_LOCK) begin
                        if (lock_s) begin
                            state_n = S_STABLE;
                            scnt_n  = '0;
                        end
                    end else if (!lock_s) begin
                        state_n = S_WAIT_LOCK;
                    end else if (scnt == S_LAST) begin
                        state_n = S_RUN;
                        retry_n = '0;
                    end else begin
                        scnt_n = scnt + 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (!lock_s || relock_req) begin
                    state_n = S_RESET_PLL;
                    pcnt_n  = '0;
`ifdef PLL_SUP_LOSS_CNT_EN
                    loss_inc = !lock_s;
`endif
                end
            end
            S_FAIL: begin
                if (relock_req) begin
                    state_n = S_RESET_PLL;
                    pcnt_n  = '0;
                    retry_n = '0;
                end
            end
            default: begin
                state_n = S_RESET_PLL;
                pcnt_n  = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge refclk) begin
        if (reset) begin
            state     <= S_RESET_PLL;
            pcnt      <= '0;
            scnt      <= '0;
            tcnt      <= '0;
            retry_cnt <= '0;
            pll_reset <= 1'b1;
            sys_rst   <= 1'b1;
            locked    <= 1'b0;
            fail      <= 1'b0;
        end else begin
            state     <= state_n;
            pcnt      <= pcnt_n;
            scnt      <= scnt_n;
            tcnt      <= tcnt_n;
            retry_cnt <= retry_n;
            pll_reset <= (state_n == S_RESET_PLL) || (state_n == S_FAIL);
            sys_rst   <= (state_n != S_RUN);
            locked    <= (state_n == S_RUN);
            fail      <= (state_n == S_FAIL);
        end
    end

`ifdef PLL_SUP_LOSS_CNT_EN
    always_ff @(posedge refclk) begin
        if (reset) begin
            lock_loss_cnt <= '0;
        end else if (loss_inc && lock_loss_cnt != 8'hFF) begin
            lock_loss_cnt <= lock_loss_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed scoreboard bench for pll_lock_supervisor.
// Small timing parameters; optional lock_loss_cnt checked when enabled.
module tb_pll_lock_supervisor;

    localparam int O_PLL = 0;
    localparam int O_SYS = 1;
    localparam int O_LCK = 2;
    localparam int O_FAIL = 3;
    localparam int O_RTY = 4;

    logic       refclk = 1'b0;
    logic       reset;
    logic       extlock;
    logic       relock_req;
    logic       pll_reset;
    logic       sys_rst;
    logic       locked;
    logic       fail;
    logic [1:0] retry_cnt;
`ifdef PLL_SUP_LOSS_CNT_EN
    logic [7:0] lock_loss_cnt;
`endif

    typedef struct {
        string tag;
        int    lo;
        int    hi;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    pll_lock_supervisor #(
        .RST_PULSE_CYC    (4),
        .LOCK_STABLE_CYC  (8),
        .LOCK_TIMEOUT_CYC (32),
        .MAX_RETRIES      (2)
    ) dut (
        .refclk        (refclk),
        .reset         (reset),
        .extlock       (extlock),
        .relock_req    (relock_req),
        .pll_reset     (pll_reset),
        .sys_rst       (sys_rst),
        .locked        (locked),
        .fail          (fail),
`ifdef PLL_SUP_LOSS_CNT_EN
        .lock_loss_cnt (lock_loss_cnt),
`endif
        .retry_cnt     (retry_cnt)
    );

    always #5 refclk = ~refclk;

    function automatic int obs(input int sel);
        case (sel)
            O_PLL:   return int'(pll_reset);
            O_SYS:   return int'(sys_rst);
            O_LCK:   return int'(locked);
            O_FAIL:  return int'(fail);
            default: return int'(retry_cnt);
        endcase
    endfunction

    task automatic push(input string tag, input int lo, input int hi);
        exp_t e;
        e.tag = tag;
        e.lo  = lo;
        e.hi  = hi;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input int o);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL sb_empty: got %0d with no expectation", o);
        end else begin
            e = sb.pop_front();
            assert (o >= e.lo && o <= e.hi) else begin
                errors++;
                $error("FAIL %s: got %0d expected %0d..%0d",
                       e.tag, o, e.lo, e.hi);
            end
        end
    endtask

    task automatic exp_now(input string tag, input int sel, input int v);
        push(tag, v, v);
        pop_chk(obs(sel));
    endtask

    task automatic wait_for(input int sel, input int val,
                            input int bound, output int n);
        n = 0;
        while (obs(sel) != val && n < bound) begin
            @(negedge refclk);
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int k;
        bit seen;

        reset      = 1'b1;
        extlock    = 1'b0;
        relock_req = 1'b0;
        repeat (3) @(negedge refclk);
        exp_now("rst_pll", O_PLL, 1);
        exp_now("rst_sys", O_SYS, 1);
        exp_now("rst_lck", O_LCK, 0);
        exp_now("rst_fail", O_FAIL, 0);
        exp_now("rst_rty", O_RTY, 0);

        // Lock appears at cycle 10 after release.
        reset = 1'b0;
        push("pulse_len0", 4, 4);
        wait_for(O_PLL, 0, 20, n);
        pop_chk(n);
        repeat (6) @(negedge refclk);
        extlock = 1'b1;
        push("lock_time", 10, 12);
        wait_for(O_LCK, 1, 40, n);
        pop_chk(n);
        exp_now("run_sys", O_SYS, 0);
        exp_now("run_rty", O_RTY, 0);

        // One-cycle lock drop in RUN.
        extlock = 1'b0;
        @(negedge refclk);
        extlock = 1'b1;
        push("drop_react", 2, 3);
        wait_for(O_SYS, 1, 8, n);
        pop_chk(n + 1);
        exp_now("drop_pll", O_PLL, 1);
        exp_now("drop_lck", O_LCK, 0);
`ifdef PLL_SUP_LOSS_CNT_EN
        push("loss_cnt1", 1, 1);
        pop_chk(int'(lock_loss_cnt));
`endif
        push("relock_time", 12, 14);
        wait_for(O_LCK, 1, 40, n);
        pop_chk(n);

        // relock_req from RUN, then lock toggling every 5 cycles.
        relock_req = 1'b1;
        @(negedge refclk);
        relock_req = 1'b0;
        extlock    = 1'b0;
        exp_now("req_pll", O_PLL, 1);
        exp_now("req_sys", O_SYS, 1);
        exp_now("req_rty", O_RTY, 0);
`ifdef PLL_SUP_LOSS_CNT_EN
        push("loss_req", 1, 1);
        pop_chk(int'(lock_loss_cnt));
`endif
        push("pulse_req", 4, 4);
        wait_for(O_PLL, 0, 10, n);
        pop_chk(n);
        extlock = 1'b1;
        k = 0;
        seen = 1'b0;
        push("tmo_time", 32, 32);
        while (k < 60) begin
            @(negedge refclk);
            k++;
            if (locked) seen = 1'b1;
            if (retry_cnt == 2'd1) break;
            if (k % 5 == 0) extlock = ~extlock;
        end
        pop_chk(k);
        push("tog_nolock", 0, 0);
        pop_chk(int'(seen));
        exp_now("tmo_pll", O_PLL, 1);

        // Reset while in STABLE with one retry used.
        extlock = 1'b1;
        push("pulse_r1", 4, 4);
        wait_for(O_PLL, 0, 10, n);
        pop_chk(n);
        repeat (4) @(negedge refclk);
        exp_now("stb_lck", O_LCK, 0);
        exp_now("stb_rty", O_RTY, 1);
        reset = 1'b1;
        @(negedge refclk);
        exp_now("mid_pll", O_PLL, 1);
        exp_now("mid_sys", O_SYS, 1);
        exp_now("mid_lck", O_LCK, 0);
        exp_now("mid_fail", O_FAIL, 0);
        exp_now("mid_rty", O_RTY, 0);
`ifdef PLL_SUP_LOSS_CNT_EN
        push("loss_rst", 0, 0);
        pop_chk(int'(lock_loss_cnt));
`endif
        extlock = 1'b0;
        @(negedge refclk);

        // No lock at all: two retries then FAIL.
        reset = 1'b0;
        push("f_pulse0", 4, 4);
        wait_for(O_PLL, 0, 10, n);
        pop_chk(n);
        push("f_tmo1", 32, 32);
        wait_for(O_PLL, 1, 50, n);
        pop_chk(n);
        exp_now("f_rty1", O_RTY, 1);
        push("f_pulse1", 4, 4);
        wait_for(O_PLL, 0, 10, n);
        pop_chk(n);
        push("f_tmo2", 32, 32);
        wait_for(O_PLL, 1, 50, n);
        pop_chk(n);
        exp_now("f_rty2", O_RTY, 2);
        push("f_pulse2", 4, 4);
        wait_for(O_PLL, 0, 10, n);
        pop_chk(n);
        push("f_tmo3", 32, 32);
        wait_for(O_FAIL, 1, 50, n);
        pop_chk(n);
        exp_now("fail_pll", O_PLL, 1);
        exp_now("fail_sys", O_SYS, 1);
        exp_now("fail_lck", O_LCK, 0);
        exp_now("fail_rty", O_RTY, 2);
        repeat (10) @(negedge refclk);
        exp_now("fail_hold", O_FAIL, 1);
        exp_now("fail_hpll", O_PLL, 1);

        relock_req = 1'b1;
        @(negedge refclk);
        relock_req = 1'b0;
        exp_now("rl_rty", O_RTY, 0);
        exp_now("rl_fail", O_FAIL, 0);
        exp_now("rl_pll", O_PLL, 1);
        push("rl_pulse", 4, 4);
        wait_for(O_PLL, 0, 10, n);
        pop_chk(n);

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL sb_left: got %0d expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
